// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA raster timing generator. It divides clk down to the pixel
//            rate and produces x/y counters, hsync/vsync and video_on.
//            Define VGA_FRAME_TICK_EN to add the frame_tick output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] c_X_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_Y_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_p_tick;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_hsync;
    logic               r_vsync;

    logic               w_tick;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic [c_DIV_W-1:0] w_div_next;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;

    // The tick condition and the counter step share one edge, so p_tick and
    // the new x/y become visible on the same clk.
    assign w_tick     = (r_div == c_DIV_LAST);
    assign w_div_next = w_tick ? '0 : r_div + 1'b1;
    assign w_x_wrap   = (r_x == c_X_LAST);
    assign w_y_wrap   = (r_y == c_Y_LAST);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (w_x_wrap) begin
                w_x_next = '0;
                w_y_next = w_y_wrap ? '0 : r_y + 1'b1;
            end else begin
                w_x_next = r_x + 1'b1;
            end
        end
    end

    // Syncs are decoded from the next-state counters to stay aligned with x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= '0;
            r_p_tick <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_p_tick <= w_tick;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_hsync  <= (w_x_next >= c_HS_START) && (w_x_next <= c_HS_END);
            r_vsync  <= (w_y_next >= c_VS_START) && (w_y_next <= c_VS_END);
        end
    end

    assign p_tick   = r_p_tick;
    assign x        = r_x;
    assign y        = r_y;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = (r_x < c_H_DISP) && (r_y < c_V_DISP);

`ifdef VGA_FRAME_TICK_EN
    logic r_frame_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_tick && w_x_wrap && w_y_wrap;
        end
    end

    assign frame_tick = r_frame_tick;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Scoreboard bench for vga_sync_gen: default timing (CLK_DIV=2),
//            default timing with CLK_DIV=1, and a small raster with a
//            mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    typedef struct {
        int         cyc;
        int         dut;
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
    } exp_t;

    localparam int c_N_EDGES = 1700;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    logic       pt_a, hs_a, vs_a, von_a, ft_a;
    logic       pt_b, hs_b, vs_b, von_b, ft_b;
    logic       pt_c, hs_c, vs_c, von_c, ft_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    vga_sync_gen #(.CLK_DIV(2)) u_dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_b)
`endif
    );

    vga_sync_gen #(.CLK_DIV(1)) u_dut_c (
        .clk(clk), .reset(rst_c), .p_tick(pt_c), .x(x_c), .y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(von_c)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_c)
`endif
    );

`ifndef VGA_FRAME_TICK_EN
    assign ft_a = 1'b0;
    assign ft_b = 1'b0;
    assign ft_c = 1'b0;
`endif

    // Expected outputs after c un-reset edges: ticks = c/d, raster position
    // follows directly from the tick count.
    function automatic exp_t model(int cyc, int dut, int c, int d,
                                   int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        exp_t e;
        int ht, vt, t, xi, yi;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t  = c / d;
        xi = t % ht;
        yi = (t / ht) % vt;
        e.cyc = cyc;
        e.dut = dut;
        e.x   = 10'(xi);
        e.y   = 10'(yi);
        e.pt  = (c > 0) && (c % d == 0);
        e.hs  = (xi >= hd + hf) && (xi < hd + hf + hs);
        e.vs  = (yi >= vd + vf) && (yi < vd + vf + vs);
        e.von = (xi < hd) && (yi < vd);
`ifdef VGA_FRAME_TICK_EN
        e.ft  = e.pt && (t % (ht * vt) == 0);
`else
        e.ft  = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: compares every queued expectation at the negedge of its cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
            e = q.pop_front();
            a = e;
            case (e.dut)
                0: begin a.x = x_a; a.y = y_a; a.pt = pt_a; a.hs = hs_a;
                         a.vs = vs_a; a.von = von_a; a.ft = ft_a; end
                1: begin a.x = x_b; a.y = y_b; a.pt = pt_b; a.hs = hs_b;
                         a.vs = vs_b; a.von = von_b; a.ft = ft_b; end
                default: begin a.x = x_c; a.y = y_c; a.pt = pt_c; a.hs = hs_c;
                         a.vs = vs_c; a.von = von_c; a.ft = ft_c; end
            endcase
            total++;
            if (e.cyc != edge_cnt || a.x !== e.x || a.y !== e.y || a.pt !== e.pt ||
                a.hs !== e.hs || a.vs !== e.vs || a.von !== e.von || a.ft !== e.ft) begin
                bad++;
                $display("FAIL dut%0d cyc=%0d got x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b exp x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b",
                         e.dut, e.cyc, a.x, a.y, a.pt, a.hs, a.vs, a.von, a.ft,
                         e.x, e.y, e.pt, e.hs, e.vs, e.von, e.ft);
            end
        end
    end

    // Stimulus: three reset edges, then free-run; dut B gets a one-clk reset
    // mid-frame and must restart at (0,0).
    initial begin
        int ca, cb, cc;
        ca = 0;
        cb = 0;
        cc = 0;
        for (int n = 1; n <= c_N_EDGES; n++) begin
            @(posedge clk);
            ca = rst_a ? 0 : ca + 1;
            cb = rst_b ? 0 : cb + 1;
            cc = rst_c ? 0 : cc + 1;
            q.push_back(model(n, 0, ca, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            q.push_back(model(n, 1, cb, 3, 8, 2, 3, 3, 4, 2, 2, 1));
            q.push_back(model(n, 2, cc, 1, 640, 16, 96, 48, 480, 10, 2, 33));
            #2;
            rst_a = (n < 3);
            rst_b = (n < 3) || (n == 250);
            rst_c = (n < 3);
        end
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d exp pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
